// File: rtl/lfsr_checker.sv
// Read-data checker: compares incoming beats against a 64-bit LFSR stream
// and records pass/fail, error count and the first failing beat.
module lfsr_checker #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 16,
   parameter int ERR_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   seed,
   input  logic [CNT_W-1:0]   num_beats,
   input  logic               rd_valid,
   output logic               rd_ready,
   input  logic [WIDTH-1:0]   rd_data,
   input  logic [WIDTH/8-1:0] rd_mask,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic               mismatch,
   output logic [ERR_W-1:0]   err_count,
   output logic [CNT_W-1:0]   first_err_idx,
   output logic [WIDTH-1:0]   first_err_data,
   output logic [WIDTH-1:0]   first_err_exp
);

   localparam int NB = WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] exp_q;
   logic [CNT_W-1:0] beat_cnt;
   logic [CNT_W-1:0] nb_q;
   logic             pass_q;
   logic             start_ok;
   logic             accept;
   logic             last_beat;
   logic             beat_fail;

   function automatic logic [WIDTH-1:0] lfsr_next(
      input logic [WIDTH-1:0] e
   );
      logic fb;
      fb = ~(e[19] ^ e[6] ^ e[2] ^ e[1]);
      return {e[WIDTH-2:0], fb};
   endfunction

   assign start_ok  = start && (state_q != RUN);
   assign accept    = rd_valid && (state_q == RUN);
   assign last_beat = accept && (beat_cnt == nb_q - CNT_W'(1));

   always_comb begin
      beat_fail = 1'b0;
      for (int b = 0; b < NB; b++) begin
         if (!rd_mask[b] &&
             (rd_data[8*b +: 8] != exp_q[8*b +: 8]))
            beat_fail = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start)
               state_d = (num_beats == '0) ? DONE : RUN;
         end
         RUN: begin
            if (last_beat) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp_q          <= '0;
         beat_cnt       <= '0;
         nb_q           <= '0;
         pass_q         <= 1'b0;
         mismatch       <= 1'b0;
         err_count      <= '0;
         first_err_idx  <= '0;
         first_err_data <= '0;
         first_err_exp  <= '0;
      end else begin
         mismatch <= accept && beat_fail;
         if (start_ok) begin
            exp_q          <= seed;
            beat_cnt       <= '0;
            nb_q           <= num_beats;
            pass_q         <= (num_beats == '0);
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            first_err_exp  <= '0;
         end else if (accept) begin
            exp_q    <= lfsr_next(exp_q);
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (beat_fail) begin
               if (err_count != '1)
                  err_count <= err_count + ERR_W'(1);
               // err_count never wraps back to 0, so 0 marks the first failure
               if (err_count == '0) begin
                  first_err_idx  <= beat_cnt;
                  first_err_data <= rd_data;
                  first_err_exp  <= exp_q;
               end
            end
            if (last_beat)
               pass_q <= (err_count == '0) && !beat_fail;
         end
      end
   end

   assign rd_ready = (state_q == RUN);
   assign busy     = rd_ready;
   assign done     = (state_q == DONE);
   assign pass     = pass_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed vector bench for lfsr_checker: per-cycle table of inputs
// and post-edge expected outputs, plus a reset-abort sequence.
module tb_lfsr_checker;

   logic        clk;
   logic        reset;
   logic        start;
   logic [63:0] seed;
   logic [15:0] num_beats;
   logic        rd_valid;
   logic        rd_ready;
   logic [63:0] rd_data;
   logic [7:0]  rd_mask;
   logic        busy;
   logic        done;
   logic        pass;
   logic        mismatch;
   logic [1:0]  err_count;
   logic [15:0] first_err_idx;
   logic [63:0] first_err_data;
   logic [63:0] first_err_exp;

   int nvec;
   int nbad;

   typedef struct {
      logic        st;
      logic [63:0] sd;
      logic [15:0] nb;
      logic        v;
      logic [63:0] d;
      logic [7:0]  m;
      logic        rdy;
      logic        dn;
      logic        ps;
      logic        mm;
      logic [1:0]  ec;
      logic        fe;
      logic [15:0] fidx;
      logic [63:0] fdat;
      logic [63:0] fexp;
   } vec_t;

   vec_t vq[$];

   lfsr_checker #(
      .WIDTH(64),
      .CNT_W(16),
      .ERR_W(2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .seed          (seed),
      .num_beats     (num_beats),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_data       (rd_data),
      .rd_mask       (rd_mask),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .mismatch      (mismatch),
      .err_count     (err_count),
      .first_err_idx (first_err_idx),
      .first_err_data(first_err_data),
      .first_err_exp (first_err_exp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(
      input logic        st,
      input logic [63:0] sd,
      input logic [15:0] nb,
      input logic        v,
      input logic [63:0] d,
      input logic [7:0]  m,
      input logic        rdy,
      input logic        dn,
      input logic        ps,
      input logic        mm,
      input logic [1:0]  ec
   );
      vec_t r;
      r.st = st; r.sd = sd; r.nb = nb;
      r.v = v; r.d = d; r.m = m;
      r.rdy = rdy; r.dn = dn; r.ps = ps;
      r.mm = mm; r.ec = ec;
      r.fe = 1'b0; r.fidx = '0;
      r.fdat = '0; r.fexp = '0;
      return r;
   endfunction

   // beat with no start
   function automatic vec_t bt(
      input logic        v,
      input logic [63:0] d,
      input logic [7:0]  m,
      input logic        rdy,
      input logic        dn,
      input logic        ps,
      input logic        mm,
      input logic [1:0]  ec
   );
      return mk(0, 0, 0, v, d, m, rdy, dn, ps, mm, ec);
   endfunction

   task automatic set_fe(
      input logic [15:0] idx,
      input logic [63:0] dat,
      input logic [63:0] ex
   );
      vq[$].fe   = 1'b1;
      vq[$].fidx = idx;
      vq[$].fdat = dat;
      vq[$].fexp = ex;
   endtask

   task automatic chk(
      input string        nm,
      input logic [159:0] act,
      input logic [159:0] req
   );
      nvec++;
      if (act !== req) begin
         nbad++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   task automatic apply(input vec_t v, input string nm);
      start     = v.st;
      seed      = v.sd;
      num_beats = v.nb;
      rd_valid  = v.v;
      rd_data   = v.d;
      rd_mask   = v.m;
      @(posedge clk);
      #1;
      chk(nm,
          160'({rd_ready, busy, done, pass, mismatch, err_count}),
          160'({v.rdy, v.rdy, v.dn, v.ps, v.mm, v.ec}));
      if (v.fe)
         chk({nm, "_first"},
             160'({first_err_idx, first_err_data, first_err_exp}),
             160'({v.fidx, v.fdat, v.fexp}));
   endtask

   task automatic chk_zero(input string nm);
      chk(nm,
          160'({rd_ready, busy, done, pass, mismatch, err_count,
                first_err_idx, first_err_data, first_err_exp}),
          160'(0));
   endtask

   initial begin
      logic [63:0] bad;
      nvec      = 0;
      nbad      = 0;
      reset     = 1'b0;
      start     = 1'b0;
      seed      = '0;
      num_beats = '0;
      rd_valid  = 1'b0;
      rd_data   = '0;
      rd_mask   = '0;
      bad       = 64'hFFFF_0000_0000_0000;

      // clean run: 0,1,3,6,D
      vq.push_back(mk(1, 0, 5, 0, 0, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(1, 64'h0, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(1, 64'h1, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(1, 64'h3, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(1, 64'h6, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(1, 64'hD, 0, 0, 1, 1, 0, 0));
      vq.push_back(bt(0, 64'h0, 0, 0, 1, 1, 0, 0));
      // beat 2 corrupted
      vq.push_back(mk(1, 0, 5, 0, 0, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(1, 64'h0, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(1, 64'h1, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(1, 64'h7, 0, 1, 0, 0, 1, 1));
      vq.push_back(bt(1, 64'h6, 0, 1, 0, 0, 0, 1));
      vq.push_back(bt(1, 64'hD, 0, 0, 1, 0, 0, 1));
      set_fe(16'd2, 64'h7, 64'h3);
      // same corruption, byte 0 masked
      vq.push_back(mk(1, 0, 5, 0, 0, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(1, 64'h0, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(1, 64'h1, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(1, 64'h7, 8'h01, 1, 0, 0, 0, 0));
      vq.push_back(bt(1, 64'h6, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(1, 64'hD, 0, 0, 1, 1, 0, 0));
      set_fe(16'd0, 64'h0, 64'h0);
      // rd_valid toggling, garbage on idle cycles
      vq.push_back(mk(1, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(1, 64'h0, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(0, 64'hFF, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(1, 64'h1, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(0, 64'hFF, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(1, 64'h3, 0, 0, 1, 1, 0, 0));
      // zero-beat run, then start ignored mid-run
      vq.push_back(mk(1, 0, 0, 1, 64'h1234, 0, 0, 1, 1, 0, 0));
      vq.push_back(mk(1, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0));
      vq.push_back(mk(1, 64'h55, 9, 1, 64'h0, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(1, 64'h1, 0, 0, 1, 1, 0, 0));
      // every beat fails: err_count saturates at 3
      vq.push_back(mk(1, 0, 5, 0, 0, 0, 1, 0, 0, 0, 0));
      vq.push_back(bt(1, bad, 0, 1, 0, 0, 1, 1));
      vq.push_back(bt(1, bad, 0, 1, 0, 0, 1, 2));
      vq.push_back(bt(1, bad, 0, 1, 0, 0, 1, 3));
      vq.push_back(bt(1, bad, 0, 1, 0, 0, 1, 3));
      vq.push_back(bt(1, bad, 0, 0, 1, 0, 1, 3));
      vq.push_back(bt(0, 64'h0, 0, 0, 1, 0, 0, 3));
      set_fe(16'd0, bad, 64'h0);

      #3;
      chk_zero("reset_state");
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < vq.size(); i++)
         apply(vq[i], $sformatf("vec%0d", i));

      // async reset mid-run after two beats
      apply(mk(1, 0, 5, 0, 0, 0, 1, 0, 0, 0, 0), "rst_start");
      apply(bt(1, 64'h0, 0, 1, 0, 0, 0, 0), "rst_b0");
      apply(bt(1, 64'h99, 0, 1, 0, 0, 1, 1), "rst_b1");
      #2;
      reset = 1'b0;
      #1;
      chk_zero("rst_async");
      start    = 1'b0;
      rd_valid = 1'b1;
      rd_data  = '0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk_zero("rst_idle");
      apply(mk(1, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0), "re_start");
      apply(bt(1, 64'h0, 0, 1, 0, 0, 0, 0), "re_b0");
      apply(bt(1, 64'h1, 0, 0, 1, 1, 0, 0), "re_b1");

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nbad);
      $finish;
   end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter WIDTH, default 64: width of the checked read-data word and of the LFSR.
REQ-002 Parameter CNT_W, default 16: width of the beat counter, num_beats and first_err_idx.
REQ-003 Parameter ERR_W, default 16: width of err_count.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 start  input  1  one-cycle request to begin a check run.
REQ-007 seed  input  WIDTH  LFSR value for beat 0, captured on accepted start.
REQ-008 num_beats  input  CNT_W  number of beats in the run, captured on accepted start.
REQ-009 rd_valid  input  1  read-data beat offered by the controller side.
REQ-010 rd_ready  output  1  checker accepts a beat this cycle.
REQ-011 rd_data  input  WIDTH  read-data beat.
REQ-012 rd_mask  input  WIDTH/8  per-byte mask; 1 = byte excluded from compare.
REQ-013 busy  output  1  run in progress.
REQ-014 done  output  1  run complete, held until next accepted start.
REQ-015 pass  output  1  valid while done=1; 1 = zero mismatches.
REQ-016 mismatch  output  1  registered one-cycle pulse per failing beat.
REQ-017 err_count  output  ERR_W  failing beats this run.
REQ-018 first_err_idx / first_err_data / first_err_exp  output  CNT_W / WIDTH / WIDTH  index, received data and expected data of the first failing beat.

Function
REQ-019 The expected-data register exp SHALL advance as: fb = NOT(exp[19] XOR exp[6] XOR exp[2] XOR exp[1]); next = {exp[WIDTH-2:0], fb}.
REQ-020 FSM states SHALL be IDLE, RUN and DONE.
REQ-021 start in IDLE or DONE SHALL: load exp<=seed, beat_cnt<=0, err_count<=0, first_err_* <=0, clear done/pass, capture num_beats, go to RUN; if num_beats==0, go directly to DONE with pass=1.
REQ-022 start while in RUN SHALL be ignored.
REQ-023 rd_ready SHALL be 1 exactly when state==RUN (no combinational path from rd_valid); busy SHALL equal rd_ready.
REQ-024 A beat SHALL be accepted when rd_valid and rd_ready are both 1; rd_valid without rd_ready SHALL have no effect.
REQ-025 For an accepted beat, byte b SHALL fail when rd_mask[b]==0 and rd_data byte b != exp byte b; the beat fails when any byte fails.
REQ-026 Each accepted beat SHALL advance exp once per REQ-019 and increment beat_cnt, whether or not the beat fails.
REQ-027 A failing beat SHALL increment err_count, saturating at 2^ERR_W-1.
REQ-028 A failing beat SHALL pulse mismatch for exactly the cycle after acceptance.
REQ-029 first_err_idx/data/exp SHALL capture beat_cnt, rd_data and exp on the first failing beat of a run only.
REQ-030 Acceptance of the beat with beat_cnt==num_beats-1 SHALL move to DONE on the next edge; done=1 and pass=(err_count==0, counting that beat) in that same cycle.
REQ-031 In DONE, rd_ready=0; done, pass, err_count and first_err_* SHALL hold until the next accepted start.
REQ-032 An all-zero seed SHALL be legal; the all-ones lock-up state is the user's responsibility and SHALL NOT be detected.

Reset
REQ-033 reset=0 SHALL immediately force state IDLE, exp=0, beat_cnt=0, and rd_ready, busy, done, pass, mismatch, err_count, first_err_* all 0.
REQ-034 Reset asserted during RUN SHALL abort the run with no done pulse; the first rising edge after release SHALL find the block in IDLE.

Verification
REQ-035 seed=0, num_beats=5, rd_mask=0, rd_valid=1, data 0x0,0x1,0x3,0x6,0xD -> rd_ready for 5 cycles, done=1, pass=1, err_count=0.
REQ-036 Same run but beat 2 = 0x7 -> mismatch pulse one cycle after beat 2, err_count=1, first_err_idx=2, first_err_data=0x7, first_err_exp=0x3, pass=0.
REQ-037 Same as REQ-036 with rd_mask=0x01 on beat 2 -> no mismatch, pass=1.
REQ-038 rd_valid toggled 1/0 each cycle, num_beats=3, correct data -> done only after 3rd accepted beat, exp advanced exactly 3 times, pass=1.
REQ-039 num_beats=0 start -> next cycle done=1, pass=1, rd_ready never 1; start again during a RUN -> ignored, run completes normally.
REQ-040 reset=0 mid-RUN after 2 beats -> all outputs 0 asynchronously; new start with seed=0 restarts at expected 0x0.
